// File: rtl/instruction_fetch.sv
// Fetch stage of the simplex8 core: owns the fetch PC, drives instruction memory and
// buffers {byte, PC} pairs in a prefetch FIFO. Optional PC wrap at MEM_LAST via FETCH_WRAP_EN.
module instruction_fetch #(
  parameter int                    PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    MEM_LAST   = 35
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic [PC_WIDTH-1:0] MEM_ADDRESS,
  output logic                MEM_EN,
  input  logic [7:0]          MEM_DATA,
  input  logic                REDIRECT,
  input  logic [PC_WIDTH-1:0] REDIRECT_PC,
  output logic [7:0]          INSTR,
  output logic [PC_WIDTH-1:0] INSTR_PC,
  output logic                INSTR_VALID,
  input  logic                INSTR_READY
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] LAST_PC   = PC_WIDTH'(MEM_LAST);

`ifdef FETCH_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [7:0]          data_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] tag_q  [FIFO_DEPTH];

  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] redirect_target;

  // Decoder handshake: the head transfers on a rising edge where INSTR_VALID and
  // INSTR_READY are both high and no redirect is flushing the FIFO.
  assign INSTR_VALID = (count_q != '0);
  assign pop         = INSTR_VALID & INSTR_READY & ~REDIRECT;
  assign MEM_EN      = RST_N & ~REDIRECT & ((count_q < DEPTH_CNT) | pop);
  assign push        = MEM_EN;
  assign MEM_ADDRESS = pc_q;

  assign INSTR    = INSTR_VALID ? data_q[rd_ptr_q] : 8'h00;
  assign INSTR_PC = INSTR_VALID ? tag_q[rd_ptr_q]  : '0;

  always_comb begin
    next_pc         = pc_q + PC_WIDTH'(1);
    redirect_target = REDIRECT_PC;
    if (WRAP_EN) begin
      if (pc_q == LAST_PC) next_pc = '0;
      if (REDIRECT_PC > LAST_PC) redirect_target = '0;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (REDIRECT) begin
      pc_d     = redirect_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = next_pc;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr_q] <= MEM_DATA;
      tag_q[wr_ptr_q]  <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: randomized and directed stimulus, queue-based reference
// of the prefetch stream, and a monitor comparing every presented head entry.
module tb_instruction_fetch;

  localparam int          PC_WIDTH   = 16;
  localparam int          FIFO_DEPTH = 4;
  localparam int          MEM_LAST   = 35;
  localparam logic [15:0] RESET_PC   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_address;
  logic        mem_en;
  logic [7:0]  mem_data;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];
  logic [23:0] head_e;
  logic [15:0] model_pc = RESET_PC;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_address];

  instruction_fetch #(
    .PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MEM_LAST(MEM_LAST)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .MEM_ADDRESS(mem_address), .MEM_EN(mem_en),
    .MEM_DATA(mem_data), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .INSTR(instr), .INSTR_PC(instr_pc), .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] pc);
`ifdef FETCH_WRAP_EN
    return (pc == 16'(MEM_LAST)) ? 16'h0000 : pc + 16'd1;
`else
    return pc + 16'd1;
`endif
  endfunction

  function automatic logic [15:0] model_target(input logic [15:0] pc);
`ifdef FETCH_WRAP_EN
    return (pc > 16'(MEM_LAST)) ? 16'h0000 : pc;
`else
    return pc;
`endif
  endfunction

  // Monitor: compares what the DUT presents against the oldest expected entry.
  always @(negedge clk) begin
    #2;
    check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %0h with nothing expected at %0t", instr_pc, $time);
      end else begin
        head_e = exp_q[0];
        check("instr", 32'(instr), 32'(head_e[23:16]));
        check("instr_pc", 32'(instr_pc), 32'(head_e[15:0]));
        if (instr_ready && !redirect) void'(exp_q.pop_front());
      end
    end else begin
      check("empty_outputs_zero", {8'h00, instr, instr_pc}, 32'h0);
    end
  end

  // Driver: applies one cycle of inputs, then advances the reference stream.
  task automatic cycle(input logic rst, input logic ready, input logic redir,
                       input logic [15:0] rpc);
    logic exp_en;
    @(negedge clk);
    rst_n       = rst;
    instr_ready = ready;
    redirect    = redir;
    redirect_pc = rpc;
    #3;
    check("mem_address", 32'(mem_address), 32'(model_pc));
    if (!rst) begin
      check("mem_en_reset", 32'(mem_en), 32'h0);
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (redir) begin
      check("mem_en_redirect", 32'(mem_en), 32'h0);
      exp_q.delete();
      model_pc = model_target(rpc);
    end else begin
      exp_en = (exp_q.size() < FIFO_DEPTH);
      check("mem_en", 32'(mem_en), 32'(exp_en));
      if (exp_en) begin
        exp_q.push_back({mem[model_pc], model_pc});
        model_pc = model_next(model_pc);
      end
    end
  endtask

  task automatic run(input int n, input logic ready);
    for (int i = 0; i < n; i++) cycle(1'b1, ready, 1'b0, 16'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(instr_valid), 32'h0);
    check("async_reset_addr", 32'(mem_address), 32'(RESET_PC));
    check("async_reset_mem_en", 32'(mem_en), 32'h0);
    check("async_reset_instr", {8'h00, instr, instr_pc}, 32'h0);
    exp_q.delete();
    model_pc = RESET_PC;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = (i < 256) ? 8'(8'h10 + i) : 8'($urandom);

    #1;
    check("reset_valid", 32'(instr_valid), 32'h0);
    check("reset_addr", 32'(mem_address), 32'(RESET_PC));
    check("reset_mem_en", 32'(mem_en), 32'h0);
    check("reset_instr", {8'h00, instr, instr_pc}, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);

    // Free-running stream, then stall/release and a full FIFO with ready toggling.
    run(20, 1'b1);
    run(10, 1'b0);
    run(12, 1'b1);
    run(6, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'(i % 2 == 0), 1'b0, 16'h0);

    // Redirect with entries buffered, across the wrap point, above MEM_LAST, back-to-back.
    run(2, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 16'h0020);
    run(6, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 16'h0021);
    run(10, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 16'h0050);
    run(5, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 16'h0010);
    cycle(1'b1, 1'b0, 1'b1, 16'h0030);
    cycle(1'b1, 1'b1, 1'b1, 16'h0022);
    run(8, 1'b1);

    // Reset pulse with the FIFO partly filled.
    run(2, 1'b0);
    pulse_reset();
    run(8, 1'b1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 48)));
    end
    run(10, 1'b1);

    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
